// File: rtl/axi_wr_fifo_push.sv
// AXI4 write-channel ingress: accepts AW/W handshakes, pushes W beats immediately and
// commits the AW descriptor on the final beat so the pop side never sees an AW without its data.
//
// state | meaning
// IDLE  | waiting for an AW handshake; W held off
// DATA  | descriptor latched; accepting W beats until the final one
module axi_wr_fifo_push #(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 256,
    parameter int LEN_WIDTH      = 8,
    parameter int AWUSER_WIDTH   = 2,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int AW_ENTRY_WIDTH = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 3 + 2 + AWUSER_WIDTH + STRB_WIDTH
) (
    input  logic                      CLK,
    input  logic                      ARESET,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [LEN_WIDTH-1:0]      AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic [AWUSER_WIDTH-1:0]   AWUSER,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [STRB_WIDTH-1:0]     WSTRB,
    input  logic                      WLAST,
    output logic                      aw_fifo_wr_en,
    output logic [AW_ENTRY_WIDTH-1:0] aw_fifo_wr_data,
    input  logic                      aw_fifo_full,
    output logic                      w_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]     w_fifo_wr_data,
    input  logic                      w_fifo_full,
    output logic                      wlast_err
);

    typedef enum logic {IDLE, DATA} state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic                    first_seen_q, first_seen_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [AWUSER_WIDTH-1:0] user_q, user_d;
    logic [STRB_WIDTH-1:0]   strb_q, strb_d;

    logic last_by_cnt;
    logic commit_try;

    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        first_seen_d    = first_seen_q;
        id_d            = id_q;
        addr_d          = addr_q;
        len_d           = len_q;
        size_d          = size_q;
        burst_d         = burst_q;
        user_d          = user_q;
        strb_d          = strb_q;
        AWREADY         = 1'b0;
        WREADY          = 1'b0;
        aw_fifo_wr_en   = 1'b0;
        aw_fifo_wr_data = '0;
        w_fifo_wr_en    = 1'b0;
        w_fifo_wr_data  = '0;
        wlast_err       = 1'b0;
        last_by_cnt     = (beat_cnt_q == len_q);
        commit_try      = 1'b0;

        // Outputs are forced low for the whole reset cycle, not just after the edge.
        if (!ARESET) begin
            case (state_q)
                IDLE: begin
                    AWREADY = !aw_fifo_full;
                    if (AWVALID && !aw_fifo_full) begin
                        id_d         = AWID;
                        addr_d       = AWADDR;
                        len_d        = AWLEN;
                        size_d       = AWSIZE;
                        burst_d      = AWBURST;
                        user_d       = AWUSER;
                        beat_cnt_d   = '0;
                        first_seen_d = 1'b0;
                        state_d      = DATA;
                    end
                end
                DATA: begin
                    WREADY          = !w_fifo_full;
                    w_fifo_wr_data  = WDATA;
                    // LEN field is the beats actually taken minus one, which equals AWLEN unless WLAST came early.
                    aw_fifo_wr_data = {id_q, addr_q, beat_cnt_q, size_q, burst_q, user_q,
                                       first_seen_q ? strb_q : WSTRB};
                    if (WVALID && !w_fifo_full) begin
                        w_fifo_wr_en = 1'b1;
                        if (!first_seen_q) begin
                            strb_d       = WSTRB;
                            first_seen_d = 1'b1;
                        end
                        if (last_by_cnt || WLAST) begin
                            commit_try    = 1'b1;
                            aw_fifo_wr_en = !aw_fifo_full;
                            wlast_err     = (last_by_cnt != WLAST);
                            state_d       = IDLE;
                        end else begin
                            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            first_seen_q <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            user_q       <= '0;
            strb_q       <= '0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            first_seen_q <= first_seen_d;
            id_q         <= id_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            user_q       <= user_d;
            strb_q       <= strb_d;
        end
    end

    // Fullness was checked at AW acceptance; a full AW FIFO at commit means another pusher exists.
    a_aw_not_full_at_commit: assert property (@(posedge CLK) disable iff (ARESET)
        commit_try |-> !aw_fifo_full);

endmodule

// File: doc/axi_wr_fifo_push.md
Name: axi_wr_fifo_push

Overview:
- Write-channel ingress stage of the AXI4 slave request path.
- Accepts AXI AW and W handshakes and pushes one descriptor per burst into the AW FIFO and one entry per data beat into the W FIFO. The downstream write pop FSM drains both FIFOs.
- Commit rule: the AW descriptor is pushed only on the last W beat of its burst. A descriptor visible in the AW FIFO therefore guarantees that all of its W beats are already in the W FIFO, so the pop side never underflows.
- Also checks WLAST against AWLEN and reports mismatches.

Parameters:
- ID_WIDTH, 4, AWID width
- ADDR_WIDTH, 64, AWADDR width
- DATA_WIDTH, 256, WDATA width; STRB_WIDTH = DATA_WIDTH/8 (derived localparam)
- LEN_WIDTH, 8, AWLEN width (bursts of 1..256 beats)
- AWUSER_WIDTH, 2, AWUSER width
- AW_ENTRY_WIDTH, derived, = ID_WIDTH+ADDR_WIDTH+LEN_WIDTH+3+2+AWUSER_WIDTH+STRB_WIDTH

Ports:
- CLK  in  1  clock
- ARESET  in  1  reset (see interface rule)
- AWVALID  in  1  AXI address valid
- AWREADY  out  1  AXI address ready
- AWID  in  ID_WIDTH
- AWADDR  in  ADDR_WIDTH
- AWLEN  in  LEN_WIDTH
- AWSIZE  in  3
- AWBURST  in  2
- AWUSER  in  AWUSER_WIDTH
- WVALID  in  1
- WREADY  out  1
- WDATA  in  DATA_WIDTH
- WSTRB  in  STRB_WIDTH
- WLAST  in  1
- aw_fifo_wr_en  out  1  AW FIFO push
- aw_fifo_wr_data  out  AW_ENTRY_WIDTH  packed descriptor
- aw_fifo_full  in  1
- w_fifo_wr_en  out  1  W FIFO push
- w_fifo_wr_data  out  DATA_WIDTH  WDATA of the beat
- w_fifo_full  in  1
- wlast_err  out  1  one-cycle pulse on WLAST/AWLEN mismatch

Behaviour:
- Interface rule: one clock, CLK; reset ARESET is synchronous and active-high. While ARESET is high, all outputs are 0. On reset: state IDLE, beat_cnt 0, latched descriptor cleared.
- Reset mid-burst:
  - Returns to IDLE and discards the latched descriptor.
  - The W and AW FIFOs share ARESET and are flushed in the same cycle.
- States: IDLE, DATA.
- IDLE:
  - AWREADY = !aw_fifo_full; WREADY = 0.
  - On AWVALID&&AWREADY: latch AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWUSER, clear beat_cnt and the first-beat flag, go to DATA.
  - W traffic is never accepted in IDLE, including when AWVALID and WVALID arrive in the same cycle.
- DATA:
  - AWREADY = 0; WREADY = !w_fifo_full.
  - Each beat (WVALID&&WREADY) drives w_fifo_wr_en = 1 and w_fifo_wr_data = WDATA in the same cycle, combinationally; there is no added latency.
  - The first beat's WSTRB is latched into the descriptor strobe field.
  - beat_cnt increments per beat.
- Final beat: a beat is final when beat_cnt == latched AWLEN, or when WLAST = 1, whichever comes first. On the final beat:
  - aw_fifo_wr_en = 1 in the same cycle as the W push.
  - State returns to IDLE the next cycle.
  - Burst turnaround is 1 idle cycle; the next AWREADY can assert the cycle after commit.
- Descriptor packing, MSB to LSB: {AWID, AWADDR, LEN, AWSIZE, AWBURST, AWUSER, first-beat WSTRB}.
  - Length-1 burst: the WSTRB field comes from the same-cycle WSTRB input.
- Early WLAST (WLAST=1 with beat_cnt < AWLEN):
  - Commit with LEN field = beat_cnt (actual beats - 1).
  - wlast_err pulses for 1 cycle.
- Missing WLAST (beat_cnt == AWLEN with WLAST=0):
  - Commit with LEN = AWLEN.
  - wlast_err pulses.
  - Subsequent stray W beats are held off by WREADY = 0 in IDLE.
- Correct WLAST: wlast_err = 0.
- AW FIFO capacity at commit:
  - Only this block pushes the AW FIFO and fullness was checked at AW acceptance, so the AW FIFO cannot be full at commit.
  - The implementation still gates aw_fifo_wr_en with !aw_fifo_full, and flags a violation with an assertion.
- W FIFO full mid-burst: WREADY drops and beat_cnt holds; the burst resumes when space frees, with no loss or duplication.
- Arithmetic: beat_cnt is LEN_WIDTH bits; AWLEN=255 is reached without wrap.
- One outstanding burst only; no interleaving.

Test Plan:
- Single beat: AWLEN=0, AWID=3, WSTRB=0xFFFF_0000, WLAST=1 → one W push; AW push the same cycle with LEN=0, ID=3, strobe 0xFFFF_0000; wlast_err=0.
- 4-beat burst with WVALID asserted continuously → 4 W pushes on consecutive cycles; AW push coincident with the 4th; AWREADY low throughout DATA, high again 1 cycle after commit.
- Back-pressure: w_fifo_full=1 for 3 cycles during beat 2 of an 8-beat burst → WREADY low for 3 cycles; exactly 8 W pushes in order; AW LEN=7.
- Early WLAST: AWLEN=7, WLAST on beat 3 → AW pushed with LEN=2; wlast_err pulses once; state returns to IDLE.
- Missing WLAST: AWLEN=1, WLAST=0 on both beats → AW LEN=1; wlast_err pulses; WREADY=0 on the following cycle.
- Reset mid-burst: ARESET=1 after beat 2 of 4 → no AW push; outputs 0 during reset; a new burst is accepted normally after ARESET falls.
